// File: rtl/pump_duty_scheduler.sv
// Pump duty scheduler: slews two pump duty requests one LSB per ramp tick,
// servicing the pumps round-robin, capping the sum of both duties to a shared
// power budget and holding pump B off for a stagger window after every halt.
module pump_duty_scheduler #(
  parameter int RAMP_DIV      = 25_000,
  parameter int STAGGER_TICKS = 500,
  parameter int BUDGET        = 320
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tgt_a,
  input  logic [7:0] tgt_b,
  input  logic       estop,
  output logic [7:0] duty_out_a,
  output logic [7:0] duty_out_b,
  output logic       budget_limited,
  output logic       settled,
  output logic [1:0] state_o
);

  localparam int CNT_W = $clog2(RAMP_DIV + 1);
  localparam int STG_W = $clog2(STAGGER_TICKS + 2);
  // Budgets of 511 and above can never bind on a 9-bit sum, so clamp there.
  localparam int BUD_C = (BUDGET > 511) ? 511 : ((BUDGET < 0) ? 0 : BUDGET);
  localparam logic [9:0]       BUD_LIM   = 10'(BUD_C);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(RAMP_DIV - 1);
  localparam logic [STG_W-1:0] STG_LOAD  = STG_W'(STAGGER_TICKS);

  typedef enum logic [1:0] {
    ST_HALT    = 2'b00,
    ST_STAGGER = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [STG_W-1:0] stag_cnt_q, stag_cnt_d;
  logic [7:0]       duty_a_q, duty_a_d;
  logic [7:0]       duty_b_q, duty_b_d;
  logic             rr_q, rr_d;        // 0 = pump A has priority, 1 = pump B
  logic             blim_q, blim_d;

  logic       tick;
  logic [7:0] eff_b;
  logic       fits;
  logic       up_a, dn_a, up_b, dn_b;
  logic       elig_a, elig_b;
  logic       serve_a, serve_b;

  // True when one more LSB on either pump keeps the combined duty in budget.
  function automatic logic inc_fits(input logic [7:0] a, input logic [7:0] b);
    logic [9:0] next_sum;
    next_sum = {2'b00, a} + {2'b00, b} + 10'd1;
    return next_sum <= BUD_LIM;
  endfunction

  // Per-pump direction, eligibility and the round-robin pick for this tick.
  always_comb begin
    tick    = (state_q != ST_HALT) && (tick_cnt_q == TICK_LAST);
    eff_b   = (state_q == ST_STAGGER) ? 8'd0 : tgt_b;
    fits    = inc_fits(duty_a_q, duty_b_q);
    up_a    = duty_a_q < tgt_a;
    dn_a    = duty_a_q > tgt_a;
    up_b    = duty_b_q < eff_b;
    dn_b    = duty_b_q > eff_b;
    elig_a  = dn_a || (up_a && fits);
    elig_b  = dn_b || (up_b && fits);
    serve_a = 1'b0;
    serve_b = 1'b0;
    if (!rr_q) begin
      if (elig_a)      serve_a = 1'b1;
      else if (elig_b) serve_b = 1'b1;
    end else begin
      if (elig_b)      serve_b = 1'b1;
      else if (elig_a) serve_a = 1'b1;
    end
  end

  // Next-state logic: estop override, halt exit, stagger countdown and stepping.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    stag_cnt_d = stag_cnt_q;
    duty_a_d   = duty_a_q;
    duty_b_d   = duty_b_q;
    rr_d       = rr_q;
    blim_d     = blim_q;
    if (estop) begin
      state_d    = ST_HALT;
      tick_cnt_d = '0;
      duty_a_d   = 8'd0;
      duty_b_d   = 8'd0;
      rr_d       = 1'b0;
      blim_d     = 1'b0;
    end else begin
      case (state_q)
        ST_HALT: begin
          tick_cnt_d = '0;
          stag_cnt_d = STG_LOAD;
          state_d    = (STAGGER_TICKS == 0) ? ST_RUN : ST_STAGGER;
        end
        ST_STAGGER, ST_RUN: begin
          tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
          if (tick) begin
            blim_d = (up_a && !fits) || (up_b && !fits);
            if (serve_a) begin
              duty_a_d = dn_a ? duty_a_q - 8'd1 : duty_a_q + 8'd1;
              rr_d     = 1'b1;
            end else if (serve_b) begin
              duty_b_d = dn_b ? duty_b_q - 8'd1 : duty_b_q + 8'd1;
              rr_d     = 1'b0;
            end
            if (state_q == ST_STAGGER) begin
              stag_cnt_d = stag_cnt_q - STG_W'(1);
              if (stag_cnt_q <= STG_W'(1)) state_d = ST_RUN;
            end
          end
        end
        default: state_d = ST_HALT;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HALT;
      tick_cnt_q <= '0;
      stag_cnt_q <= '0;
      duty_a_q   <= 8'd0;
      duty_b_q   <= 8'd0;
      rr_q       <= 1'b0;
      blim_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      duty_a_q   <= duty_a_d;
      duty_b_q   <= duty_b_d;
      rr_q       <= rr_d;
      blim_q     <= blim_d;
    end
  end

  assign duty_out_a     = duty_a_q;
  assign duty_out_b     = duty_b_q;
  assign budget_limited = blim_q;
  assign settled        = (state_q == ST_RUN) && (duty_a_q == tgt_a) && (duty_b_q == tgt_b);
  assign state_o        = state_q;

endmodule

// File: tb/tb_pump_duty_scheduler.sv
// Bench for pump_duty_scheduler: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a behavioural model.
module tb_pump_duty_scheduler;

  localparam int RAMP_DIV      = 4;
  localparam int STAGGER_TICKS = 3;
  localparam int BUDGET        = 300;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       estop = 1'b0;
  logic [7:0] tgt_a = 8'd0;
  logic [7:0] tgt_b = 8'd0;
  logic [7:0] duty_out_a, duty_out_b;
  logic       budget_limited, settled;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: mode 0 halted, 1 staggering, 2 running.
  int m_mode = 0;
  int m_cyc = 0;
  int m_stag = 0;
  int m_a = 0;
  int m_b = 0;
  int m_pri = 0;
  int m_blim = 0;

  always #5 clk = ~clk;

  pump_duty_scheduler #(
    .RAMP_DIV(RAMP_DIV),
    .STAGGER_TICKS(STAGGER_TICKS),
    .BUDGET(BUDGET)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tgt_a(tgt_a),
    .tgt_b(tgt_b),
    .estop(estop),
    .duty_out_a(duty_out_a),
    .duty_out_b(duty_out_b),
    .budget_limited(budget_limited),
    .settled(settled),
    .state_o(state_o)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // One ramp tick of the model: pick a pump by priority, move it one step.
  task automatic model_tick();
    int cur[2];
    int goal[2];
    int sum;
    int pick;
    bit room;
    bit elig[2];
    cur[0]  = m_a;
    cur[1]  = m_b;
    goal[0] = int'(tgt_a);
    goal[1] = (m_mode == 1) ? 0 : int'(tgt_b);
    sum     = m_a + m_b;
    room    = (sum + 1) <= BUDGET;
    m_blim  = 0;
    for (int i = 0; i < 2; i++) begin
      elig[i] = (cur[i] > goal[i]) || ((cur[i] < goal[i]) && room);
      if ((cur[i] < goal[i]) && !room) m_blim = 1;
    end
    pick = -1;
    if (elig[m_pri])          pick = m_pri;
    else if (elig[1 - m_pri]) pick = 1 - m_pri;
    if (pick >= 0) begin
      cur[pick] += (cur[pick] > goal[pick]) ? -1 : 1;
      m_pri = 1 - pick;
    end
    m_a = cur[0];
    m_b = cur[1];
    if (m_mode == 1) begin
      m_stag--;
      if (m_stag == 0) m_mode = 2;
    end
  endtask

  // Advance the model once per clock edge, or clear it on reset.
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_mode = 0; m_cyc = 0; m_a = 0; m_b = 0; m_pri = 0; m_blim = 0; m_stag = 0;
    end else if (estop) begin
      m_mode = 0; m_cyc = 0; m_a = 0; m_b = 0; m_pri = 0; m_blim = 0;
    end else if (m_mode == 0) begin
      m_mode = (STAGGER_TICKS == 0) ? 2 : 1;
      m_stag = STAGGER_TICKS;
      m_cyc  = 0;
    end else begin
      m_cyc++;
      if (m_cyc == RAMP_DIV) begin
        m_cyc = 0;
        model_tick();
      end
    end
  end

  // Compare every output against the model shortly after each clock edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (!reset) begin
      check("duty_a", int'(duty_out_a), m_a);
      check("duty_b", int'(duty_out_b), m_b);
      check("budget_limited", int'(budget_limited), m_blim);
      check("state", int'(state_o), m_mode);
      check("settled", int'(settled),
            int'(m_mode == 2 && m_a == int'(tgt_a) && m_b == int'(tgt_b)));
    end
  end

  task automatic restart(input int a, input int b);
    @(negedge clk);
    estop = 1'b1;
    tgt_a = 8'(a);
    tgt_b = 8'(b);
    @(negedge clk);
    check("lit_estop_a", int'(duty_out_a), 0);
    check("lit_estop_b", int'(duty_out_b), 0);
    check("lit_estop_state", int'(state_o), 0);
    estop = 1'b0;
  endtask

  initial begin
    tgt_a = 8'd10;
    tgt_b = 8'd0;
    #1 reset = 1'b1;
    #1;
    check("lit_rst_a", int'(duty_out_a), 0);
    check("lit_rst_b", int'(duty_out_b), 0);
    check("lit_rst_blim", int'(budget_limited), 0);
    check("lit_rst_settled", int'(settled), 0);
    check("lit_rst_state", int'(state_o), 0);
    @(negedge clk);
    #2 reset = 1'b0;

    // Pump A alone ramps to 10 after ten ticks.
    repeat (41) @(posedge clk);
    @(negedge clk);
    check("lit_s1_a", int'(duty_out_a), 10);
    check("lit_s1_b", int'(duty_out_b), 0);
    check("lit_s1_settled", int'(settled), 1);

    // Stagger then alternate to 5/5.
    restart(5, 5);
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("lit_s2_a3", int'(duty_out_a), 3);
    check("lit_s2_b0", int'(duty_out_b), 0);
    check("lit_s2_run", int'(state_o), 2);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("lit_s2_b1", int'(duty_out_b), 1);
    repeat (24) @(posedge clk);
    @(negedge clk);
    check("lit_s2_a5", int'(duty_out_a), 5);
    check("lit_s2_b5", int'(duty_out_b), 5);
    check("lit_s2_settled", int'(settled), 1);

    // Budget caps the combined ramp at 300.
    restart(200, 200);
    repeat (1300) @(posedge clk);
    @(negedge clk);
    check("lit_s3_a", int'(duty_out_a), 151);
    check("lit_s3_b", int'(duty_out_b), 149);
    check("lit_s3_blim", int'(budget_limited), 1);
    check("lit_s3_settled", int'(settled), 0);

    // Dropping A frees budget for B.
    tgt_a = 8'd100;
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("lit_s4_a", int'(duty_out_a), 100);
    check("lit_s4_b", int'(duty_out_b), 200);
    check("lit_s4_blim", int'(budget_limited), 0);
    check("lit_s4_settled", int'(settled), 1);

    // Reversal mid-ramp.
    restart(80, 0);
    repeat (241) @(posedge clk);
    @(negedge clk);
    check("lit_s5_a60", int'(duty_out_a), 60);
    tgt_a = 8'd40;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("lit_s5_a59", int'(duty_out_a), 59);
    repeat (76) @(posedge clk);
    @(negedge clk);
    check("lit_s5_a40", int'(duty_out_a), 40);
    check("lit_s5_settled", int'(settled), 1);

    // Estop coincident with a tick, then restart; then async reset mid-ramp.
    restart(100, 80);
    repeat (740) @(posedge clk);
    @(negedge clk);
    check("lit_s6_a100", int'(duty_out_a), 100);
    check("lit_s6_b80", int'(duty_out_b), 80);
    estop = 1'b1;
    @(negedge clk);
    check("lit_s6_stop_a", int'(duty_out_a), 0);
    check("lit_s6_stop_b", int'(duty_out_b), 0);
    check("lit_s6_stop_state", int'(state_o), 0);
    estop = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check("lit_s6_re_a3", int'(duty_out_a), 3);
    check("lit_s6_re_b0", int'(duty_out_b), 0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("lit_s6_rst_a", int'(duty_out_a), 0);
    check("lit_s6_rst_b", int'(duty_out_b), 0);
    check("lit_s6_rst_state", int'(state_o), 0);
    #1 reset = 1'b0;

    // Randomized targets with occasional emergency stops.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) tgt_a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) tgt_b = 8'($urandom_range(0, 255));
      estop = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    estop = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
